sram_arbiter: RTL and testbench

- Single owner of the SRAM controller request port (address/data_write/data_read/read/write/ready).
- Serves three requesters and replaces the ad-hoc buffer state machine in top.
  - Video line-fill word reads: highest priority, line-time deadline.
  - Camera pixel draws, done as a read-modify-write of one word: middle priority.
  - Framebuffer erase, done as a background burst yielding between words: lowest priority.

---
 rtl/sram_arb_pkg.sv | 17 +
 rtl/fb_pixel_addr.sv | 19 +
 rtl/sram_arbiter.sv | 139 +++++++++++++
 tb/tb_sram_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: arbiter states and framebuffer geometry shared by the SRAM arbiter and pixel blocks
package sram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VID_RD,
        DRAW_RD,
        DRAW_WR,
        ERASE_WR
    } state_t;

    localparam int FB_W           = 640;
    localparam int FB_H           = 480;
    localparam int WORDS_PER_LINE = FB_W / 16;
    localparam int FB_WORDS       = WORDS_PER_LINE * FB_H;

endpackage

// File: rtl/fb_pixel_addr.sv
// fb_pixel_addr: maps a pixel (x, y) to its framebuffer word address, bit mask and range flag
module fb_pixel_addr
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
) (
    input  logic [9:0]        x,
    input  logic [8:0]        y,
    output logic [ADDR_W-1:0] word,
    output logic [DATA_W-1:0] mask,
    output logic              in_range
);

    assign word     = ADDR_W'(x[9:4]) + (ADDR_W'(y) << 5) + (ADDR_W'(y) << 3);
    assign mask     = DATA_W'(1) << (4'd15 - x[3:0]);
    assign in_range = int'(x) < FB_W && int'(y) < FB_H;

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: sole owner of the SRAM controller port, serving video reads, pixel RMW draws and background erase
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 16,
    parameter int WORDS_PER_LINE = sram_arb_pkg::WORDS_PER_LINE,
    parameter int FB_WORDS       = WORDS_PER_LINE * FB_H
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_busy,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_data,
    input  logic              draw_req,
    input  logic [9:0]        draw_x,
    input  logic [8:0]        draw_y,
    output logic              draw_busy,
    output logic              draw_ack,
    input  logic              erase_start,
    output logic              erase_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic              mem_ready
);

    state_t            state;
    logic              vid_pend, draw_pend, draw_ok;
    logic [ADDR_W-1:0] vid_addr_q, erase_cnt, draw_word;
    logic [9:0]        draw_x_q;
    logic [8:0]        draw_y_q;
    logic [DATA_W-1:0] draw_mask;

    fb_pixel_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pix (
        .x        (draw_x_q),
        .y        (draw_y_q),
        .word     (draw_word),
        .mask     (draw_mask),
        .in_range (draw_ok)
    );

    assign vid_busy  = vid_pend || state == VID_RD;
    assign draw_busy = draw_pend || state == DRAW_RD || state == DRAW_WR;

    // request capture, fixed-priority non-preemptive arbitration and the SRAM handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            vid_pend   <= 1'b0;
            vid_addr_q <= '0;
            vid_ack    <= 1'b0;
            vid_data   <= '0;
            draw_pend  <= 1'b0;
            draw_x_q   <= '0;
            draw_y_q   <= '0;
            draw_ack   <= 1'b0;
            erase_busy <= 1'b0;
            erase_cnt  <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
        end else begin
            vid_ack  <= 1'b0;
            draw_ack <= 1'b0;
            if (vid_req && !vid_busy) begin
                vid_pend   <= 1'b1;
                vid_addr_q <= vid_addr;
            end
            if (draw_req && !draw_busy) begin
                draw_pend <= 1'b1;
                draw_x_q  <= draw_x;
                draw_y_q  <= draw_y;
            end
            if (erase_start) begin
                erase_busy <= 1'b1;
                erase_cnt  <= '0;
            end
            case (state)
                IDLE: begin
                    if (vid_pend) begin
                        vid_pend <= 1'b0;
                        mem_addr <= vid_addr_q;
                        mem_read <= 1'b1;
                        state    <= VID_RD;
                    end else if (draw_pend) begin
                        draw_pend <= 1'b0;
                        if (draw_ok) begin
                            mem_addr <= draw_word;
                            mem_read <= 1'b1;
                            state    <= DRAW_RD;
                        end else begin
                            draw_ack <= 1'b1;
                        end
                    end else if (erase_busy) begin
                        mem_addr  <= erase_start ? '0 : erase_cnt;
                        mem_wdata <= '0;
                        mem_write <= 1'b1;
                        state     <= ERASE_WR;
                    end
                end
                VID_RD: if (mem_ready) begin
                    mem_read <= 1'b0;
                    vid_data <= mem_rdata;
                    vid_ack  <= 1'b1;
                    state    <= IDLE;
                end
                // the write follows the read directly so nothing can slip into the RMW
                DRAW_RD: if (mem_ready) begin
                    mem_read  <= 1'b0;
                    mem_wdata <= mem_rdata | draw_mask;
                    mem_write <= 1'b1;
                    state     <= DRAW_WR;
                end
                DRAW_WR: if (mem_ready) begin
                    mem_write <= 1'b0;
                    draw_ack  <= 1'b1;
                    state     <= IDLE;
                end
                // a restart landing on a completion wins, so word 0 is not skipped
                ERASE_WR: if (mem_ready) begin
                    mem_write <= 1'b0;
                    state     <= IDLE;
                    if (!erase_start) begin
                        erase_cnt <= erase_cnt + 1'b1;
                        if (erase_cnt == ADDR_W'(FB_WORDS - 1)) erase_busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vectors against an SRAM controller model with hand-computed expectations
module tb_sram_arbiter;

    typedef struct packed {
        logic        w;
        logic [17:0] a;
        logic [15:0] d;
        logic        eb;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        vid_req, draw_req, erase_start;
    logic [17:0] vid_addr;
    logic [9:0]  draw_x;
    logic [8:0]  draw_y;
    logic        vid_busy, vid_ack, draw_busy, draw_ack, erase_busy;
    logic [15:0] vid_data, mem_wdata, mem_rdata;
    logic [17:0] mem_addr;
    logic        mem_read, mem_write, mem_ready;

    int   total = 0, bad = 0;
    int   lat, lat_cnt, cyc, vid_ack_n, draw_ack_n, vid_ack_cyc, rd81_cyc, rw_n, both_n;
    logic rd_q;
    acc_t log_q[$];
    acc_t exp_e [5] = '{'{1'b1, 18'd0, 16'h0, 1'b1}, '{1'b1, 18'd1, 16'h0, 1'b1},
                        '{1'b0, 18'h28, 16'hA5A5, 1'b1}, '{1'b1, 18'd2, 16'h0, 1'b1},
                        '{1'b1, 18'd3, 16'h0, 1'b1}};

    sram_arbiter #(.FB_WORDS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .vid_req     (vid_req),
        .vid_addr    (vid_addr),
        .vid_busy    (vid_busy),
        .vid_ack     (vid_ack),
        .vid_data    (vid_data),
        .draw_req    (draw_req),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .draw_busy   (draw_busy),
        .draw_ack    (draw_ack),
        .erase_start (erase_start),
        .erase_busy  (erase_busy),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_ready   (mem_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rd_val(input logic [17:0] a);
        return a == 18'h28 ? 16'hA5A5 : a == 18'd81 ? 16'h0001 : a[15:0] ^ 16'h5A00;
    endfunction

    // SRAM controller model: ready pulses lat cycles after read/write is first seen
    always @(posedge clk) begin
        if (reset || mem_ready || !(mem_read || mem_write)) begin
            lat_cnt   <= 1;
            mem_ready <= 1'b0;
        end else if (lat_cnt >= lat) begin
            mem_ready <= 1'b1;
            mem_rdata <= rd_val(mem_addr);
            log_q.push_back('{mem_write, mem_addr, mem_write ? mem_wdata : rd_val(mem_addr), erase_busy});
        end else begin
            lat_cnt <= lat_cnt + 1;
        end
    end

    // cycle monitor for acks, read rises and illegal handshake overlap
    always @(negedge clk) begin
        cyc  <= cyc + 1;
        rd_q <= mem_read;
        if (vid_ack) begin
            vid_ack_n   <= vid_ack_n + 1;
            vid_ack_cyc <= cyc;
        end
        if (draw_ack) draw_ack_n <= draw_ack_n + 1;
        if (mem_read && !rd_q && mem_addr == 18'd81) rd81_cyc <= cyc;
        if (mem_read || mem_write) rw_n <= rw_n + 1;
        if (mem_read && mem_write) both_n <= both_n + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input string tag, input int exp_n);
        int n = 0;
        while (!mem_ready && n < 60) begin
            tick(1);
            n++;
        end
        chk(tag, 64'(n), 64'(exp_n));
    endtask

    task automatic wait_draw_ack(input string tag);
        for (int i = 0; i < 200 && !draw_ack; i++) tick(1);
        chk(tag, draw_ack, 1);
    endtask

    initial begin
        int b, va, da, rw;
        cyc = 0; vid_ack_n = 0; draw_ack_n = 0; vid_ack_cyc = 0; rd81_cyc = 0; rw_n = 0; both_n = 0; rd_q = 0;
        lat = 3;
        reset = 1'b1;
        vid_req = 0; draw_req = 0; erase_start = 0;
        vid_addr = '0; draw_x = '0; draw_y = '0;
        tick(2);
        chk("rst_outs", {mem_read, mem_write, vid_busy, vid_ack, draw_busy, draw_ack, erase_busy}, 0);
        chk("rst_data", {vid_data, mem_addr, mem_wdata}, 0);
        reset = 1'b0;
        tick(1);

        // single video read
        vid_req = 1; vid_addr = 18'h28;
        tick(1);
        vid_req = 0;
        chk("vid_pend", {vid_busy, mem_read}, 2'b10);
        tick(1);
        chk("vid_grant", {mem_read, mem_write, mem_addr}, {2'b10, 18'h28});
        wait_rdy("vid_lat", 3);
        chk("vid_hold", {mem_read, mem_addr}, {1'b1, 18'h28});
        tick(1);
        chk("vid_done", {vid_ack, vid_busy, mem_read, vid_data}, {3'b100, 16'hA5A5});
        tick(1);
        chk("vid_ack_pulse", vid_ack, 0);

        // in-range draw read-modify-write
        b = log_q.size(); da = draw_ack_n;
        draw_req = 1; draw_x = 10'd17; draw_y = 9'd2;
        tick(1);
        draw_req = 0;
        wait_draw_ack("draw_ack");
        chk("draw_busy_end", draw_busy, 0);
        tick(3);
        chk("draw_n_acc", log_q.size() - b, 2);
        chk("draw_rd", log_q[b], {1'b0, 18'd81, 16'h0001, 1'b0});
        chk("draw_wr", log_q[b+1], {1'b1, 18'd81, 16'h4001, 1'b0});
        chk("draw_ack_once", draw_ack_n - da, 1);

        // simultaneous video and draw: video first
        b = log_q.size(); va = vid_ack_n; da = draw_ack_n;
        vid_req = 1; vid_addr = 18'h28;
        draw_req = 1; draw_x = 10'd17; draw_y = 9'd2;
        tick(1);
        vid_req = 0; draw_req = 0;
        chk("both_busy", {vid_busy, draw_busy}, 2'b11);
        wait_draw_ack("sim_draw_ack");
        tick(3);
        chk("sim_n_acc", log_q.size() - b, 3);
        chk("sim_vid", log_q[b], {1'b0, 18'h28, 16'hA5A5, 1'b0});
        chk("sim_drd", log_q[b+1], {1'b0, 18'd81, 16'h0001, 1'b0});
        chk("sim_dwr", log_q[b+2], {1'b1, 18'd81, 16'h4001, 1'b0});
        chk("sim_acks", {32'(vid_ack_n - va), 32'(draw_ack_n - da)}, {32'd1, 32'd1});
        chk("sim_order", rd81_cyc, vid_ack_cyc + 1);

        // erase of four words with a video read slipping in after the second write
        b = log_q.size();
        erase_start = 1;
        tick(1);
        erase_start = 0;
        chk("erase_busy", erase_busy, 1);
        for (int i = 0; i < 100 && log_q.size() < b + 2; i++) tick(1);
        vid_req = 1; vid_addr = 18'h28;
        tick(1);
        vid_req = 0;
        for (int i = 0; i < 200 && erase_busy; i++) tick(1);
        chk("erase_done", erase_busy, 0);
        tick(5);
        chk("erase_n_acc", log_q.size() - b, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("erase_acc%0d", i), log_q[b+i], exp_e[i]);

        // out-of-range draw: ack one cycle after grant, no memory traffic
        b = log_q.size(); rw = rw_n;
        draw_req = 1; draw_x = 10'd700; draw_y = 9'd10;
        tick(1);
        draw_req = 0;
        chk("oor_pend", {draw_busy, draw_ack}, 2'b10);
        tick(1);
        chk("oor_ack", {draw_ack, draw_busy, mem_read, mem_write}, 4'b1000);
        tick(1);
        chk("oor_ack_pulse", draw_ack, 0);
        tick(4);
        chk("oor_no_mem", {32'(rw_n - rw), 32'(log_q.size() - b)}, 0);

        // asynchronous reset while the draw write is outstanding
        lat = 30;
        erase_start = 1;
        draw_req = 1; draw_x = 10'd17; draw_y = 9'd2;
        tick(1);
        erase_start = 0; draw_req = 0;
        for (int i = 0; i < 200 && !mem_write; i++) tick(1);
        chk("rmw_in_wr", {mem_write, mem_addr, mem_wdata}, {1'b1, 18'd81, 16'h4001});
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst", {mem_read, mem_write, draw_busy, erase_busy, vid_busy}, 0);
        chk("async_rst_data", vid_data, 0);
        tick(2);
        reset = 1'b0;
        lat = 3;
        tick(2);
        chk("post_rst_idle", {mem_read, mem_write, erase_busy}, 0);
        vid_req = 1; vid_addr = 18'h30;
        tick(1);
        vid_req = 0;
        tick(1);
        chk("post_rst_grant", {mem_read, mem_addr}, {1'b1, 18'h30});
        wait_rdy("post_rst_lat", 3);
        tick(1);
        chk("post_rst_vid", {vid_ack, vid_data}, {1'b1, 16'h5A30});
        chk("never_both", both_n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
